uc_stack: RTL and testbench

UC_STACK -- requirements
Module: uc_stack

---
 rtl/uc_pkg.sv | 42 ++++
 rtl/uc_decode.sv | 55 +++++
 rtl/uc_stack.sv | 133 +++++++++++++
 tb/tb_uc_stack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the micro-controller control unit: FSM states,
// jump-condition codes, opcode class prefixes and the halt opcode.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_CALL_T = 3'd1,
        ST_RET_T  = 3'd2,
        ST_HALT   = 3'd3,
        ST_FAULT  = 3'd4
    } uc_state_e;

    // Conditional-jump selectors carried in opcode[11:10]
    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    // Opcode class prefixes, matched against the top bits of the opcode
    localparam logic       PFX_IMM  = 1'b1;
    localparam logic [1:0] PFX_REG  = 2'b01;
    localparam logic [2:0] PFX_JMP  = 3'b001;
    localparam logic [3:0] PFX_CALL = 4'b0001;
    localparam logic [4:0] PFX_RET  = 5'b00001;

    localparam logic [15:0] HALT_OPCODE = 16'h0001;

    // True when the selected flag condition holds
    function automatic logic cond_true(input logic [1:0] cond,
                                       input logic       z,
                                       input logic       carry);
        logic res;
        case (cond)
            COND_Z:  res = z;
            COND_NZ: res = !z;
            COND_C:  res = carry;
            default: res = !carry;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Pure combinational opcode decode. Produces the datapath controls an
// opcode asks for in a RUN cycle, plus class strobes for call/return/halt
// that the sequencing FSM in uc_stack acts on.
import uc_pkg::*;

module uc_decode #(
    parameter int ALU_OP_W = 3
) (
    input  logic [15:0]         opcode_i,
    input  logic                z_i,
    input  logic                carry_i,
    output logic                s_inc_o,
    output logic                s_inm_o,
    output logic                we3_o,
    output logic                wez_o,
    output logic [ALU_OP_W-1:0] op_alu_o,
    output logic                is_call_o,
    output logic                is_ret_o,
    output logic                is_halt_o
);

    // Priority decode on the opcode class prefix; unmatched 00000xxx is a nop
    always_comb begin
        s_inc_o   = 1'b1;
        s_inm_o   = 1'b0;
        we3_o     = 1'b0;
        wez_o     = 1'b0;
        op_alu_o  = '0;
        is_call_o = 1'b0;
        is_ret_o  = 1'b0;
        is_halt_o = 1'b0;
        if (opcode_i[15] == PFX_IMM) begin
            s_inm_o       = 1'b1;
            we3_o         = 1'b1;
            wez_o         = opcode_i[11];
            op_alu_o[2:0] = opcode_i[14:12];
            if (ALU_OP_W == 4) op_alu_o[ALU_OP_W-1] = opcode_i[10];
        end else if (opcode_i[15:14] == PFX_REG) begin
            we3_o         = 1'b1;
            wez_o         = opcode_i[3];
            op_alu_o[2:0] = opcode_i[6:4];
            if (ALU_OP_W == 4) op_alu_o[ALU_OP_W-1] = opcode_i[7];
        end else if (opcode_i[15:13] == PFX_JMP) begin
            // Unconditional jumps always load; conditional ones only when taken
            s_inc_o = opcode_i[12] ? !cond_true(opcode_i[11:10], z_i, carry_i) : 1'b0;
        end else if (opcode_i[15:12] == PFX_CALL) begin
            is_call_o = 1'b1;
        end else if (opcode_i[15:11] == PFX_RET) begin
            is_ret_o = 1'b1;
        end else if (opcode_i == HALT_OPCODE) begin
            is_halt_o = 1'b1;
        end
    end

endmodule

// File: rtl/uc_stack.sv
// Control unit top: sequences call/return over two cycles, tracks the
// return-stack depth, and latches halt and stack-fault conditions.
// A call or return is a one-opcode, two-cycle operation: the first cycle
// pushes/pops with PC stalled, the second loads PC (jump target or stack top).
// A boundary violation stalls the core in FAULT until reset.
import uc_pkg::*;

module uc_stack #(
    parameter int STACK_DEPTH = 16,
    parameter int ALU_OP_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         opcode,
    input  logic                z,
    input  logic                carry,
    output logic                s_inc,
    output logic                s_inm,
    output logic                s_ret,
    output logic                we3,
    output logic                wez,
    output logic                push,
    output logic                pop,
    output logic [ALU_OP_W-1:0] op_alu,
    output logic                stall,
    output logic                halted,
    output logic                stack_err
);

    localparam int                   DEPTH_W   = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    uc_state_e            state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 stack_err_q, stack_err_d;

    logic                 dec_s_inc, dec_s_inm, dec_we3, dec_wez;
    logic [ALU_OP_W-1:0]  dec_op_alu;
    logic                 dec_call, dec_ret, dec_halt;
    logic                 in_run, call_ok, call_bad, ret_ok, ret_bad;

    uc_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
        .opcode_i  (opcode),
        .z_i       (z),
        .carry_i   (carry),
        .s_inc_o   (dec_s_inc),
        .s_inm_o   (dec_s_inm),
        .we3_o     (dec_we3),
        .wez_o     (dec_wez),
        .op_alu_o  (dec_op_alu),
        .is_call_o (dec_call),
        .is_ret_o  (dec_ret),
        .is_halt_o (dec_halt)
    );

    // Decode only counts in RUN; other states ignore the opcode entirely
    assign in_run   = (state_q == ST_RUN);
    assign call_ok  = in_run && dec_call && (depth_q <  DEPTH_MAX);
    assign call_bad = in_run && dec_call && (depth_q == DEPTH_MAX);
    assign ret_ok   = in_run && dec_ret  && (depth_q != '0);
    assign ret_bad  = in_run && dec_ret  && (depth_q == '0);

    // State, depth and sticky fault registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            depth_q     <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Next-state, depth update and fault latch
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        stack_err_d = stack_err_q | call_bad | ret_bad;
        if (call_ok) depth_d = depth_q + DEPTH_W'(1);
        else if (ret_ok) depth_d = depth_q - DEPTH_W'(1);
        case (state_q)
            ST_RUN: begin
                if (call_ok)                 state_d = ST_CALL_T;
                else if (ret_ok)             state_d = ST_RET_T;
                else if (call_bad | ret_bad) state_d = ST_FAULT;
                else if (dec_halt)           state_d = ST_HALT;
            end
            ST_CALL_T: state_d = ST_RUN;
            ST_RET_T:  state_d = ST_RUN;
            ST_HALT:   state_d = ST_HALT;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_RUN;
        endcase
    end

    // Output decode per state; reset low gates everything to the idle pattern.
    // The violating call/return cycle already stalls so PC never moves past it.
    always_comb begin
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        s_ret     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        op_alu    = '0;
        stall     = 1'b0;
        halted    = (state_q == ST_HALT);
        stack_err = stack_err_q;
        if (reset) begin
            case (state_q)
                ST_RUN: begin
                    s_inc  = dec_s_inc;
                    s_inm  = dec_s_inm;
                    we3    = dec_we3;
                    wez    = dec_wez;
                    op_alu = dec_op_alu;
                    push   = call_ok;
                    pop    = ret_ok;
                    stall  = call_ok | call_bad | ret_ok | ret_bad;
                end
                ST_CALL_T: s_inc = 1'b0;
                ST_RET_T:  s_ret = 1'b1;
                ST_HALT:   stall = 1'b1;
                ST_FAULT:  stall = 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_stack.sv
// Bench for uc_stack: directed opcode vectors with literal expectations,
// plus a cycle-by-cycle reference model compared on every falling edge.
module tb_uc_stack;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [15:0] opcode;
    logic        z;
    logic        carry;
    logic        s_inc, s_inm, s_ret, we3, wez, push, pop, stall, halted, stack_err;
    logic [2:0]  op_alu;

    int checks = 0;
    int errors = 0;

    // Output vector: {s_inc,s_inm,s_ret,we3,wez,push,pop,op_alu[2:0],stall,halted,stack_err}
    logic [12:0] act;
    logic [12:0] exp_q[$];
    assign act = {s_inc, s_inm, s_ret, we3, wez, push, pop, op_alu, stall, halted, stack_err};

    uc_stack #(.STACK_DEPTH(DEPTH), .ALU_OP_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .z         (z),
        .carry     (carry),
        .s_inc     (s_inc),
        .s_inm     (s_inm),
        .s_ret     (s_ret),
        .we3       (we3),
        .wez       (wez),
        .push      (push),
        .pop       (pop),
        .op_alu    (op_alu),
        .stall     (stall),
        .halted    (halted),
        .stack_err (stack_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [12:0] mk(input bit inc, input bit inm, input bit ret,
                                       input bit we, input bit wz, input bit pu,
                                       input bit po, input logic [2:0] alu,
                                       input bit st, input bit ha, input bit er);
        return {inc, inm, ret, we, wz, pu, po, alu, st, ha, er};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs just after a rising edge; return once outputs have settled
    task automatic drive(input logic [15:0] op, input logic zz, input logic cc);
        @(posedge clk);
        #2;
        opcode = op;
        z      = zz;
        carry  = cc;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset  = 1'b0;
        opcode = 16'h0000;
        z      = 1'b0;
        carry  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #2;
    endtask

    // ---------------- reference model ----------------
    // Abstract model state: stack depth and which phase the control unit is in
    int m_depth = 0;
    bit m_call2 = 0, m_ret2 = 0, m_halt = 0, m_fault = 0;
    int m_depth_nx = 0;
    bit m_call2_nx = 0, m_ret2_nx = 0, m_halt_nx = 0, m_fault_nx = 0;

    // Compare on every falling edge, then work out what the model becomes at the next rising edge
    always @(negedge clk) begin : compare
        bit e_inc, e_inm, e_ret, e_we, e_wz, e_pu, e_po, e_st, e_ha, e_er;
        logic [2:0] e_alu;
        int nd;
        bit nc, nr, nh, nf;
        e_inc = 1; e_inm = 0; e_ret = 0; e_we = 0; e_wz = 0; e_pu = 0; e_po = 0;
        e_st = 0; e_ha = 0; e_er = 0; e_alu = 3'd0;
        nd = m_depth; nc = 0; nr = 0; nh = m_halt; nf = m_fault;
        if (reset !== 1'b1) begin
            nd = 0; nh = 0; nf = 0;
        end else if (m_halt) begin
            e_st = 1; e_ha = 1;
        end else if (m_fault) begin
            e_st = 1; e_er = 1;
        end else if (m_call2) begin
            e_inc = 0;
        end else if (m_ret2) begin
            e_ret = 1;
        end else if (opcode[15]) begin
            e_inm = 1; e_we = 1; e_alu = opcode[14:12]; e_wz = opcode[11];
        end else if (opcode[14]) begin
            e_we = 1; e_alu = opcode[6:4]; e_wz = opcode[3];
        end else if (opcode[13]) begin
            if (!opcode[12]) e_inc = 0;
            else begin
                case (opcode[11:10])
                    2'b00: e_inc = !z;
                    2'b01: e_inc = z;
                    2'b10: e_inc = !carry;
                    default: e_inc = carry;
                endcase
            end
        end else if (opcode[12]) begin
            e_st = 1;
            if (m_depth < DEPTH) begin e_pu = 1; nc = 1; nd = m_depth + 1; end
            else nf = 1;
        end else if (opcode[11]) begin
            e_st = 1;
            if (m_depth > 0) begin e_po = 1; nr = 1; nd = m_depth - 1; end
            else nf = 1;
        end else if (opcode == 16'h0001) begin
            nh = 1;
        end
        exp_q.push_back({e_inc, e_inm, e_ret, e_we, e_wz, e_pu, e_po, e_alu, e_st, e_ha, e_er});
        check("model_outputs", {19'd0, act}, {19'd0, exp_q.pop_front()});
        check("model_depth", {27'd0, dut.depth_q}, m_depth);
        m_depth_nx = nd; m_call2_nx = nc; m_ret2_nx = nr; m_halt_nx = nh; m_fault_nx = nf;
    end

    always @(posedge clk or negedge reset) begin : model_commit
        if (!reset) begin
            m_depth <= 0; m_call2 <= 0; m_ret2 <= 0; m_halt <= 0; m_fault <= 0;
        end else begin
            m_depth <= m_depth_nx; m_call2 <= m_call2_nx; m_ret2 <= m_ret2_nx;
            m_halt  <= m_halt_nx;  m_fault <= m_fault_nx;
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [12:0] O_DEF = 13'h1000;

    initial begin : stim
        reset  = 1'b0;
        opcode = 16'hA5FF;
        z      = 1'b0;
        carry  = 1'b0;
        #7;
        // Reset holds outputs idle even with a live ALU opcode on the bus
        check("reset_gated", {19'd0, act}, {19'd0, O_DEF});
        check("reset_depth", {27'd0, dut.depth_q}, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #2;

        // Immediate ALU
        drive(16'hAD3C, 0, 0);
        check("imm_wez1", {19'd0, act}, {19'd0, mk(1,1,0,1,1,0,0,3'b010,0,0,0)});
        drive(16'hA5C3, 0, 0);
        check("imm_wez0", {19'd0, act}, {19'd0, mk(1,1,0,1,0,0,0,3'b010,0,0,0)});
        // Register ALU
        drive(16'h40DA, 0, 0);
        check("reg_alu_a", {19'd0, act}, {19'd0, mk(1,0,0,1,1,0,0,3'b101,0,0,0)});
        drive(16'h7F35, 0, 0);
        check("reg_alu_b", {19'd0, act}, {19'd0, mk(1,0,0,1,0,0,0,3'b011,0,0,0)});
        // Jumps
        drive(16'h2000, 1, 1);
        check("jmp_uncond", {19'd0, act}, {19'd0, mk(0,0,0,0,0,0,0,3'd0,0,0,0)});
        drive(16'h3400, 1, 0);
        check("jmp_nz_z1", {19'd0, act}, {19'd0, O_DEF});
        drive(16'h3400, 0, 0);
        check("jmp_nz_z0", {19'd0, act}, {19'd0, mk(0,0,0,0,0,0,0,3'd0,0,0,0)});
        drive(16'h3000, 1, 0);
        check("jmp_z_z1", {19'd0, act}, {19'd0, mk(0,0,0,0,0,0,0,3'd0,0,0,0)});
        drive(16'h3800, 0, 0);
        check("jmp_c_c0", {19'd0, act}, {19'd0, O_DEF});
        drive(16'h3C00, 1, 0);
        check("jmp_nc_c0", {19'd0, act}, {19'd0, mk(0,0,0,0,0,0,0,3'd0,0,0,0)});
        // Nops
        drive(16'h0000, 0, 0);
        check("nop_0000", {19'd0, act}, {19'd0, O_DEF});
        drive(16'h0702, 1, 1);
        check("nop_0702", {19'd0, act}, {19'd0, O_DEF});

        // Call then return; flag wiggles in the second cycles must not matter
        drive(16'h1000, 0, 0);
        check("call_c1", {19'd0, act}, {19'd0, mk(1,0,0,0,0,1,0,3'd0,1,0,0)});
        drive(16'h1000, 1, 1);
        check("call_c2", {19'd0, act}, {19'd0, mk(0,0,0,0,0,0,0,3'd0,0,0,0)});
        check("call_depth", {27'd0, dut.depth_q}, 1);
        drive(16'h0800, 0, 0);
        check("ret_c1", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,1,3'd0,1,0,0)});
        drive(16'hAD3C, 1, 0);
        check("ret_c2_ignores_op", {19'd0, act}, {19'd0, mk(1,0,1,0,0,0,0,3'd0,0,0,0)});
        check("ret_depth", {27'd0, dut.depth_q}, 0);

        // Reset asserted in the middle of CALL_T
        drive(16'h1000, 0, 0);
        check("midcall_push", {19'd0, act}, {19'd0, mk(1,0,0,0,0,1,0,3'd0,1,0,0)});
        @(posedge clk);
        #3;
        check("midcall_callt", {19'd0, act}, {19'd0, mk(0,0,0,0,0,0,0,3'd0,0,0,0)});
        reset = 1'b0;
        #1;
        check("midcall_gated", {19'd0, act}, {19'd0, O_DEF});
        @(posedge clk);
        #2;
        reset = 1'b1;
        #2;
        check("midcall_depth0", {27'd0, dut.depth_q}, 0);
        check("midcall_redecode", {19'd0, act}, {19'd0, mk(1,0,0,0,0,1,0,3'd0,1,0,0)});
        do_reset();

        // Fill the stack, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            drive(16'h1000, 0, 0);
            check($sformatf("fill_push_%0d", i + 1), {31'd0, push}, 1);
            drive(16'h1000, 0, 0);
            check($sformatf("fill_callt_%0d", i + 1), {31'd0, s_inc}, 0);
        end
        check("full_depth", {27'd0, dut.depth_q}, DEPTH);
        drive(16'h1000, 0, 0);
        check("ovf_c1", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,0,0)});
        drive(16'h1000, 0, 0);
        check("ovf_c2", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,0,1)});
        drive(16'hAD3C, 0, 0);
        check("ovf_hold", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,0,1)});
        check("ovf_depth", {27'd0, dut.depth_q}, DEPTH);
        do_reset();
        check("ovf_cleared", {19'd0, act}, {19'd0, O_DEF});

        // Underflow
        drive(16'h0800, 0, 0);
        check("udf_c1", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,0,0)});
        drive(16'h0800, 0, 0);
        check("udf_c2", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,0,1)});
        drive(16'h0FFF, 0, 0);
        check("udf_hold", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,0,1)});
        do_reset();

        // Halt
        drive(16'h0001, 0, 0);
        check("halt_c1", {19'd0, act}, {19'd0, O_DEF});
        drive(16'h0001, 0, 0);
        check("halt_c2", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,1,0)});
        drive(16'h1000, 0, 0);
        check("halt_hold", {19'd0, act}, {19'd0, mk(1,0,0,0,0,0,0,3'd0,1,1,0)});
        do_reset();
        check("halt_cleared", {19'd0, act}, {19'd0, O_DEF});

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
